// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 ALU issue stage: ALU opcodes,
// RV32I major opcodes, issue FSM state encoding and the issued bundle.
package msrv32_pkg;

    localparam int XLEN = 32;

    // ALU opcode is {instr[30], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Issue FSM: number of valid entries held (output register + skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } issue_state_t;

    // One issued ALU bundle
    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      opcode;
        logic [4:0]      rd;
        logic            illegal;
    } issue_bundle_t;

endpackage

// File: rtl/msrv32_issue_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into ALU operands,
// ALU opcode and destination register. Undecodable words come out as an
// illegal ADD with zeroed operands and rd.
module msrv32_issue_decode
    import msrv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rs1_in,
    input  logic [WIDTH-1:0] rs2_in,
    output logic [WIDTH-1:0] op_1_out,
    output logic [WIDTH-1:0] op_2_out,
    output logic [3:0]       opcode_out,
    output logic [4:0]       rd_addr_out,
    output logic             illegal_out
);

    logic [6:0]       major;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] shamt;

    assign major  = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];
    assign imm_i  = {{(WIDTH-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_u  = {instr_in[31:12], 12'b0};
    assign shamt  = {{(WIDTH-5){1'b0}}, instr_in[24:20]};

    logic             legal;
    logic [WIDTH-1:0] op1_raw;
    logic [WIDTH-1:0] op2_raw;
    logic [3:0]       alu_raw;

    // Field extraction per major opcode, then squash everything on illegal
    always_comb begin
        legal   = 1'b0;
        op1_raw = '0;
        op2_raw = '0;
        alu_raw = ALU_ADD;
        case (major)
            OPC_OP: begin
                // bit30 only legal for SUB and SRA
                legal   = (funct7 == FUNCT7_ZERO) ||
                          ((funct7 == FUNCT7_ALT) &&
                           ((funct3 == 3'b000) || (funct3 == 3'b101)));
                op1_raw = rs1_in;
                op2_raw = rs2_in;
                alu_raw = {instr_in[30], funct3};
            end
            OPC_OP_IMM: begin
                op1_raw = rs1_in;
                case (funct3)
                    3'b001: begin
                        legal   = (funct7 == FUNCT7_ZERO);
                        op2_raw = shamt;
                        alu_raw = ALU_SLL;
                    end
                    3'b101: begin
                        legal   = (funct7 == FUNCT7_ZERO) || (funct7 == FUNCT7_ALT);
                        op2_raw = shamt;
                        alu_raw = instr_in[30] ? ALU_SRA : ALU_SRL;
                    end
                    default: begin
                        // imm[10] is immediate data here, never a SUB select
                        legal   = 1'b1;
                        op2_raw = imm_i;
                        alu_raw = {1'b0, funct3};
                    end
                endcase
            end
            OPC_LUI: begin
                legal   = 1'b1;
                op2_raw = imm_u;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                op1_raw = pc_in;
                op2_raw = imm_u;
            end
            default: legal = 1'b0;
        endcase

        op_1_out    = legal ? op1_raw : '0;
        op_2_out    = legal ? op2_raw : '0;
        opcode_out  = legal ? alu_raw : ALU_ADD;
        rd_addr_out = legal ? instr_in[11:7] : 5'd0;
        illegal_out = ~legal;
    end

endmodule

// File: rtl/msrv32_alu_issue.sv
// ALU issue stage: decodes one instruction per cycle and presents the ALU
// bundle behind a valid/ready interface with a 2-entry skid buffer
// (output register + skid register). in_ready_out is a flop, so there is
// no combinational path from out_ready_in back upstream.
// Optional build macro MSRV32_ISSUE_STATS_EN adds issue/stall counters.
module msrv32_alu_issue
    import msrv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rs1_in,
    input  logic [WIDTH-1:0] rs2_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] op_1_out,
    output logic [WIDTH-1:0] op_2_out,
    output logic [3:0]       opcode_out,
    output logic [4:0]       rd_addr_out,
    output logic             illegal_out
`ifdef MSRV32_ISSUE_STATS_EN
    ,
    output logic [31:0]      issue_cnt_out,
    output logic [31:0]      stall_cnt_out
`endif
);

    issue_bundle_t dec_bundle;

    msrv32_issue_decode #(.WIDTH(WIDTH)) u_decode (
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .rs1_in      (rs1_in),
        .rs2_in      (rs2_in),
        .op_1_out    (dec_bundle.op1),
        .op_2_out    (dec_bundle.op2),
        .opcode_out  (dec_bundle.opcode),
        .rd_addr_out (dec_bundle.rd),
        .illegal_out (dec_bundle.illegal)
    );

    issue_state_t  state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    issue_bundle_t out_q, out_d;
    issue_bundle_t skid_q, skid_d;

    logic accept;
    logic drain;

    assign accept = in_valid_in & in_ready_q & ~flush_in;
    assign drain  = out_valid_q & out_ready_in;

    // Next-state and data movement; flush overrides accept and drain
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_in) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        out_d   = dec_bundle;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = dec_bundle;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = dec_bundle;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Upstream is stalled here, so only a drain can happen
                    if (drain) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, handshake flags and bundle registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready_out  = in_ready_q;
    assign out_valid_out = out_valid_q;
    assign op_1_out      = out_q.op1;
    assign op_2_out      = out_q.op2;
    assign opcode_out    = out_q.opcode;
    assign rd_addr_out   = out_q.rd;
    assign illegal_out   = out_q.illegal;

`ifdef MSRV32_ISSUE_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Free-running wrap-around counters, untouched by flush
    always_comb begin
        issue_cnt_d = issue_cnt_q + {31'd0, drain};
        stall_cnt_d = stall_cnt_q + {31'd0, (out_valid_q & ~out_ready_in)};
    end

    // Counter registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt_out = issue_cnt_q;
    assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Testbench for msrv32_alu_issue: directed vectors with literal checks plus
// a queue-based reference model compared on every falling clock edge.
module tb_msrv32_alu_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        ill;
`ifdef MSRV32_ISSUE_STATS_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
`endif

    msrv32_alu_issue #(.WIDTH(32)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .flush_in      (flush),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .instr_in      (instr),
        .pc_in         (pc),
        .rs1_in        (rs1),
        .rs2_in        (rs2),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .op_1_out      (op1),
        .op_2_out      (op2),
        .opcode_out    (opc),
        .rd_addr_out   (rd),
        .illegal_out   (ill)
`ifdef MSRV32_ISSUE_STATS_EN
        ,
        .issue_cnt_out (issue_cnt),
        .stall_cnt_out (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        bit          ok;
        logic [6:0]  major;
        logic [2:0]  f3;
        logic [6:0]  f7;
        major = i[6:0];
        f3    = i[14:12];
        f7    = i[31:25];
        ok    = 0;
        e.op1 = 0; e.op2 = 0; e.opc = 4'h0; e.rd = i[11:7]; e.ill = 0;
        if (major == 7'h33) begin
            e.op1 = a; e.op2 = b;
            if (f7 == 7'h00) begin ok = 1; e.opc = {1'b0, f3}; end
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin ok = 1; e.opc = {1'b1, f3}; end
        end else if (major == 7'h13) begin
            e.op1 = a;
            if (f3 == 3'd1) begin
                ok = (f7 == 7'h00); e.op2 = {27'd0, i[24:20]}; e.opc = 4'b0001;
            end else if (f3 == 3'd5) begin
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                e.op2 = {27'd0, i[24:20]};
                e.opc = (f7 == 7'h20) ? 4'b1101 : 4'b0101;
            end else begin
                ok = 1; e.op2 = {{20{i[31]}}, i[31:20]}; e.opc = {1'b0, f3};
            end
        end else if (major == 7'h37) begin
            ok = 1; e.op1 = 0; e.op2 = {i[31:12], 12'h000}; e.opc = 4'h0;
        end else if (major == 7'h17) begin
            ok = 1; e.op1 = p; e.op2 = {i[31:12], 12'h000}; e.opc = 4'h0;
        end
        if (!ok) begin
            e.op1 = 0; e.op2 = 0; e.opc = 4'h0; e.rd = 0; e.ill = 1;
        end
        return e;
    endfunction

    exp_t mdl_q[$];
    bit   mdl_ready = 1'b1;

    // Model: a bounded FIFO of 2 entries, ready registered from its occupancy
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_q.delete();
            mdl_ready = 1'b1;
        end else begin
            bit acc;
            bit drn;
            acc = in_valid && mdl_ready && !flush;
            drn = (mdl_q.size() != 0) && out_ready;
            if (flush) begin
                mdl_q.delete();
            end else begin
                if (drn) void'(mdl_q.pop_front());
                if (acc) mdl_q.push_back(ref_decode(instr, pc, rs1, rs2));
            end
            mdl_ready = (mdl_q.size() < 2);
        end
    end

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin
        chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, mdl_q.size() != 0});
        chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, mdl_ready});
        if (mdl_q.size() != 0) begin
            chk("cmp_op1", op1, mdl_q[0].op1);
            chk("cmp_op2", op2, mdl_q[0].op2);
            chk("cmp_opcode", {28'd0, opc}, {28'd0, mdl_q[0].opc});
            chk("cmp_rd", {27'd0, rd}, {27'd0, mdl_q[0].rd});
            chk("cmp_illegal", {31'd0, ill}, {31'd0, mdl_q[0].ill});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] i, input logic [31:0] p,
                            input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1      = a;
        rs2      = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    logic [31:0] rand_tbl [8];

    initial begin
        rand_tbl[0] = 32'h002081B3;  // add
        rand_tbl[1] = 32'h402081B3;  // sub
        rand_tbl[2] = 32'h40335293;  // srai
        rand_tbl[3] = 32'h123450B7;  // lui
        rand_tbl[4] = 32'h00001117;  // auipc
        rand_tbl[5] = 32'h0000007F;  // illegal
        rand_tbl[6] = 32'h80000093;  // addi -2048
        rand_tbl[7] = 32'h4020E1B3;  // or with bad funct7

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 0; pc = 0; rs1 = 0; rs2 = 0;
        repeat (2) tick();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_op1", op1, 32'd0);
        chk("rst_op2", op2, 32'd0);
        chk("rst_opcode", {28'd0, opc}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_illegal", {31'd0, ill}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD x3, x1, x2
        set_beat(32'h002081B3, 32'h100, 32'd5, 32'd7);
        tick();
        idle();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_opcode", {28'd0, opc}, 32'h0);
        chk("add_op1", op1, 32'd5);
        chk("add_op2", op2, 32'd7);
        chk("add_rd", {27'd0, rd}, 32'd3);
        chk("add_illegal", {31'd0, ill}, 32'd0);

        // SUB
        set_beat(32'h402081B3, 32'h104, 32'd10, 32'd3);
        tick();
        chk("sub_opcode", {28'd0, opc}, 32'h8);

        // ADDI x1, x0, -2048
        set_beat(32'h80000093, 32'h108, 32'd0, 32'd0);
        tick();
        chk("addi_neg_opcode", {28'd0, opc}, 32'h0);
        chk("addi_neg_op2", op2, 32'hFFFFF800);

        // ADDI with imm[10]=1 must not turn into SUB
        set_beat(32'h40000093, 32'h10C, 32'd1, 32'd0);
        tick();
        chk("addi_b30_opcode", {28'd0, opc}, 32'h0);
        chk("addi_b30_op2", op2, 32'h00000400);

        // SRAI x5, x6, 3
        set_beat(32'h40335293, 32'h110, 32'h80000000, 32'd0);
        tick();
        chk("srai_opcode", {28'd0, opc}, 32'hD);
        chk("srai_op2", op2, 32'd3);
        chk("srai_rd", {27'd0, rd}, 32'd5);
        chk("srai_op1", op1, 32'h80000000);

        // LUI x1, 0x12345
        set_beat(32'h123450B7, 32'h114, 32'hDEAD, 32'hBEEF);
        tick();
        chk("lui_op1", op1, 32'd0);
        chk("lui_op2", op2, 32'h12345000);
        chk("lui_opcode", {28'd0, opc}, 32'h0);

        // AUIPC x2, 1
        set_beat(32'h00001117, 32'h400, 32'd9, 32'd9);
        tick();
        chk("auipc_op1", op1, 32'h400);
        chk("auipc_op2", op2, 32'h1000);

        // SLLI with funct7=0100000 is illegal
        set_beat(32'h40331293, 32'h118, 32'd4, 32'd4);
        tick();
        chk("slli_bad_illegal", {31'd0, ill}, 32'd1);

        // OR with funct7=0100000 is illegal
        set_beat(32'h4020E1B3, 32'h11C, 32'd4, 32'd4);
        tick();
        chk("or_bad_illegal", {31'd0, ill}, 32'd1);
        chk("or_bad_rd", {27'd0, rd}, 32'd0);

        // Unknown opcode
        set_beat(32'h0000007F, 32'h120, 32'h1234, 32'h5678);
        tick();
        idle();
        chk("ill_illegal", {31'd0, ill}, 32'd1);
        chk("ill_opcode", {28'd0, opc}, 32'h0);
        chk("ill_op1", op1, 32'd0);
        chk("ill_op2", op2, 32'd0);
        repeat (2) tick();

        // Back-pressure: three beats against a stalled sink
        out_ready = 1'b0;
        set_beat(32'h002081B3, 32'h200, 32'hA, 32'd0);
        tick();
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        set_beat(32'h002081B3, 32'h204, 32'hB, 32'd0);
        tick();
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        set_beat(32'h002081B3, 32'h208, 32'hC, 32'd0);
        tick();
        chk("bp_hold_op1", op1, 32'hA);
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_second_op1", op1, 32'hB);
        tick();
        idle();
        chk("bp_third_op1", op1, 32'hC);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a beat presented
        out_ready = 1'b0;
        set_beat(32'h002081B3, 32'h300, 32'h1, 32'd0);
        tick();
        set_beat(32'h002081B3, 32'h304, 32'h2, 32'd0);
        tick();
        set_beat(32'h002081B3, 32'h308, 32'h3, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_no_issue", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset pulse mid-stream
        out_ready = 1'b0;
        set_beat(32'h002081B3, 32'h400, 32'h55, 32'h66);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_op1", op1, 32'd0);
        chk("arst_op2", op2, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        tick();

        // Mixed traffic checked against the model
        for (int k = 0; k < 80; k++) begin
            set_beat(rand_tbl[$urandom_range(0, 7)], $urandom, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        repeat (4) tick();
        chk("final_empty", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
